// File: rtl/rle_pkg.sv
// ---------------------------------------------------------------------------
// rle_pkg
// Shared definitions for the run-length tokenizer:
//   - rle_state_e : tokenizer FSM states (IDLE / RUN / FLUSH)
//   - TOK_SHORT_W : bit length of a literal token {flag, byte}
//   - tok_long_w  : bit length of a run token {flag, byte, run field}
//   - LIT_FLAG / RUN_FLAG : leading flag bit of each token kind
//   - VB_W        : width of the valid_bits length field
// ---------------------------------------------------------------------------
package rle_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } rle_state_e;

   localparam int   TOK_SHORT_W = 9;
   localparam int   VB_W        = 7;
   localparam logic LIT_FLAG    = 1'b0;
   localparam logic RUN_FLAG    = 1'b1;

   // Run token length: literal part plus the run-count field.
   function automatic logic [VB_W-1:0] tok_long_w(input int run_w);
      return VB_W'(TOK_SHORT_W + run_w);
   endfunction

endpackage

// File: rtl/rle_tokenizer_if.sv
// ---------------------------------------------------------------------------
// rle_tokenizer_if
// Byte-in / token-out bundle of the tokenizer.
//   in_data[7:0]   : input byte
//   in_valid       : in_data valid this cycle
//   in_last        : byte is the last of its message (qualified by in_valid)
//   in_ready       : tokenizer accepts a byte this cycle
//   stall          : packer is not sampling; tokenizer outputs hold
//   data_out[63:0] : right-aligned token code, MSB transmitted first
//   valid_bits[6:0]: token length in bits, 0 = no token
//   msg_fin        : token is the last of its message
// master = byte source / packer side, slave = tokenizer.
// ---------------------------------------------------------------------------
interface rle_tokenizer_if;
   import rle_pkg::*;

   logic [7:0]      in_data;
   logic            in_valid;
   logic            in_last;
   logic            in_ready;
   logic            stall;
   logic [63:0]     data_out;
   logic [VB_W-1:0] valid_bits;
   logic            msg_fin;

   modport master (
      output in_data, in_valid, in_last, stall,
      input  in_ready, data_out, valid_bits, msg_fin
   );

   modport slave (
      input  in_data, in_valid, in_last, stall,
      output in_ready, data_out, valid_bits, msg_fin
   );

endinterface

// File: rtl/rle_token_fmt.sv
// ---------------------------------------------------------------------------
// rle_token_fmt
// Combinational token formatter: (byte, run length) -> (code, length).
//   i_byte[7:0]      : run byte
//   i_cnt[RUN_W:0]   : run length L (1..2**RUN_W+1)
//   o_code[63:0]     : right-aligned token, zero above o_len
//   o_len[6:0]       : token length in bits
// L==1 -> {LIT_FLAG, byte}           (9 bits)
// L>=2 -> {RUN_FLAG, byte, L-2}      (9+RUN_W bits)
// ---------------------------------------------------------------------------
module rle_token_fmt
   import rle_pkg::*;
#(
   parameter int RUN_W = 8
) (
   input  logic [7:0]      i_byte,
   input  logic [RUN_W:0]  i_cnt,
   output logic [63:0]     o_code,
   output logic [VB_W-1:0] o_len
);

   localparam int              CNT_W     = RUN_W + 1;
   localparam logic [VB_W-1:0] LEN_SHORT = VB_W'(TOK_SHORT_W);
   localparam logic [VB_W-1:0] LEN_LONG  = tok_long_w(RUN_W);
   localparam logic [CNT_W-1:0] CNT_TWO  = CNT_W'(2);

   logic [RUN_W-1:0] w_field;

   // Run field stores L-2 so a full RUN_W-bit field reaches 2**RUN_W+1.
   assign w_field = RUN_W'(i_cnt - CNT_TWO);

   // Select literal or run token layout from the run length.
   always_comb begin
      o_code = 64'd0;
      o_len  = LEN_SHORT;
      if (i_cnt >= CNT_TWO) begin
         o_code = 64'({RUN_FLAG, i_byte, w_field});
         o_len  = LEN_LONG;
      end else begin
         o_code = 64'({LIT_FLAG, i_byte});
         o_len  = LEN_SHORT;
      end
   end

endmodule

// File: rtl/rle_tokenizer.sv
// ---------------------------------------------------------------------------
// rle_tokenizer
// Run-length front end of the compression path. Collapses repeated input
// bytes into literal/run tokens and presents one token per cycle in the
// packer's data_out / valid_bits / msg_fin format.
//   clk  : single rising-edge clock
//   rst  : synchronous active-high reset (overrides stall)
//   bus  : rle_tokenizer_if.slave (byte input handshake + token output)
// RUN_W (2..8) sets the run field width; longest run is 2**RUN_W+1.
// Outputs are registered: a token caused by the byte accepted in cycle N
// is visible in N+1; a FLUSH token (break on the last byte) in N+2.
// ---------------------------------------------------------------------------
module rle_tokenizer
   import rle_pkg::*;
#(
   parameter int RUN_W = 8
) (
   input logic            clk,
   input logic            rst,
   rle_tokenizer_if.slave bus
);

   localparam int               CNT_W   = RUN_W + 1;
   localparam int               MAX_RUN = (2 ** RUN_W) + 1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_RUN);

   rle_state_e       r_state;
   rle_state_e       w_state_nxt;
   logic [7:0]       r_cur_byte;
   logic [7:0]       w_byte_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [CNT_W-1:0] w_cnt_inc;
   logic [63:0]      r_data_out;
   logic [63:0]      w_data_nxt;
   logic [VB_W-1:0]  r_valid_bits;
   logic [VB_W-1:0]  w_vb_nxt;
   logic             r_msg_fin;
   logic             w_fin_nxt;
   logic             w_emit;
   logic             w_in_ready;
   logic             w_accept;
   logic             w_extend;
   logic [7:0]       w_fmt_byte;
   logic [CNT_W-1:0] w_fmt_cnt;
   logic [63:0]      w_fmt_code;
   logic [VB_W-1:0]  w_fmt_len;

   // No byte is taken in FLUSH: the pending single-byte run must leave first.
   assign w_in_ready = !bus.stall && (r_state != FLUSH);
   assign w_accept   = bus.in_valid && w_in_ready;
   assign w_cnt_inc  = r_cnt + CNT_ONE;
   // A run only grows on an exact byte match below the maximum length.
   assign w_extend   = (bus.in_data == r_cur_byte) && (r_cnt < CNT_MAX);

   rle_token_fmt #(
      .RUN_W (RUN_W)
   ) u_fmt (
      .i_byte (w_fmt_byte),
      .i_cnt  (w_fmt_cnt),
      .o_code (w_fmt_code),
      .o_len  (w_fmt_len)
   );

   // Next-state, run bookkeeping and token selection.
   always_comb begin
      w_state_nxt = r_state;
      w_byte_nxt  = r_cur_byte;
      w_cnt_nxt   = r_cnt;
      w_emit      = 1'b0;
      w_fin_nxt   = 1'b0;
      w_fmt_byte  = r_cur_byte;
      w_fmt_cnt   = r_cnt;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_byte_nxt = bus.in_data;
               w_cnt_nxt  = CNT_ONE;
               if (bus.in_last) begin
                  // One-byte message: literal straight out.
                  w_emit      = 1'b1;
                  w_fin_nxt   = 1'b1;
                  w_fmt_byte  = bus.in_data;
                  w_fmt_cnt   = CNT_ONE;
                  w_state_nxt = IDLE;
               end else begin
                  w_state_nxt = RUN;
               end
            end else begin
               w_state_nxt = IDLE;
            end
         end
         RUN: begin
            if (w_accept) begin
               if (w_extend) begin
                  w_cnt_nxt = w_cnt_inc;
                  if (bus.in_last) begin
                     // Last byte joins the run: emit the grown run as final.
                     w_emit      = 1'b1;
                     w_fin_nxt   = 1'b1;
                     w_fmt_cnt   = w_cnt_inc;
                     w_state_nxt = IDLE;
                  end else begin
                     w_state_nxt = RUN;
                  end
               end else begin
                  // Break or full run: flush the current run, start anew.
                  w_emit     = 1'b1;
                  w_fin_nxt  = 1'b0;
                  w_byte_nxt = bus.in_data;
                  w_cnt_nxt  = CNT_ONE;
                  if (bus.in_last) begin
                     w_state_nxt = FLUSH;
                  end else begin
                     w_state_nxt = RUN;
                  end
               end
            end else begin
               w_state_nxt = RUN;
            end
         end
         FLUSH: begin
            w_emit      = 1'b1;
            w_fin_nxt   = 1'b1;
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = {CNT_W{1'b0}};
            w_byte_nxt  = 8'd0;
         end
      endcase
   end

   // Idle cycles drive an all-zero token.
   assign w_data_nxt = w_emit ? w_fmt_code : 64'd0;
   assign w_vb_nxt   = w_emit ? w_fmt_len  : {VB_W{1'b0}};

   // State and output registers; frozen while the packer stalls.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= IDLE;
         r_cur_byte   <= 8'd0;
         r_cnt        <= {CNT_W{1'b0}};
         r_data_out   <= 64'd0;
         r_valid_bits <= {VB_W{1'b0}};
         r_msg_fin    <= 1'b0;
      end else if (!bus.stall) begin
         r_state      <= w_state_nxt;
         r_cur_byte   <= w_byte_nxt;
         r_cnt        <= w_cnt_nxt;
         r_data_out   <= w_data_nxt;
         r_valid_bits <= w_vb_nxt;
         r_msg_fin    <= w_fin_nxt & w_emit;
      end
   end

   assign bus.in_ready   = w_in_ready;
   assign bus.data_out   = r_data_out;
   assign bus.valid_bits = r_valid_bits;
   assign bus.msg_fin    = r_msg_fin;

endmodule

// File: tb/tb_rle_tokenizer.sv
// ---------------------------------------------------------------------------
// tb_rle_tokenizer
// Directed bench for rle_tokenizer (RUN_W=8). Inputs are driven on the
// falling edge; in_ready is sampled 1 time unit later, and registered
// outputs are sampled on the following falling edge.
// ---------------------------------------------------------------------------
module tb_rle_tokenizer;

   logic clk;
   logic rst;
   int   total;
   int   bad;
   int   nz;

   rle_tokenizer_if bus ();

   rle_tokenizer #(
      .RUN_W (8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Apply inputs for one cycle, check in_ready before the edge, advance.
   task automatic cyc(input string tag, input logic [7:0] d, input logic v,
                      input logic l, input logic s, input logic exp_rdy);
      bus.in_data  = d;
      bus.in_valid = v;
      bus.in_last  = l;
      bus.stall    = s;
      #1;
      total++;
      assert (bus.in_ready === exp_rdy) else begin
         bad++;
         $error("FAIL %s in_ready got %b want %b", tag, bus.in_ready, exp_rdy);
      end
      @(negedge clk);
   endtask

   // Compare the registered token outputs.
   task automatic chk(input string tag, input logic [63:0] exp_d,
                      input logic [6:0] exp_vb, input logic exp_fin);
      total++;
      assert (bus.data_out === exp_d) else begin
         bad++;
         $error("FAIL %s data_out got %h want %h", tag, bus.data_out, exp_d);
      end
      total++;
      assert (bus.valid_bits === exp_vb) else begin
         bad++;
         $error("FAIL %s valid_bits got %0d want %0d", tag, bus.valid_bits, exp_vb);
      end
      total++;
      assert (bus.msg_fin === exp_fin) else begin
         bad++;
         $error("FAIL %s msg_fin got %b want %b", tag, bus.msg_fin, exp_fin);
      end
   endtask

   initial begin
      total        = 0;
      bad          = 0;
      nz           = 0;
      rst          = 1'b1;
      bus.in_data  = 8'h00;
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      bus.stall    = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset", 64'h0, 7'd0, 1'b0);
      rst = 1'b0;

      // AA AA AA BB(last): run of 3, then FLUSHed literal, one ready bubble.
      cyc("t1_aa0", 8'hAA, 1'b1, 1'b0, 1'b0, 1'b1);
      chk("t1_aa0", 64'h0, 7'd0, 1'b0);
      cyc("t1_aa1", 8'hAA, 1'b1, 1'b0, 1'b0, 1'b1);
      chk("t1_aa1", 64'h0, 7'd0, 1'b0);
      cyc("t1_aa2", 8'hAA, 1'b1, 1'b0, 1'b0, 1'b1);
      chk("t1_aa2", 64'h0, 7'd0, 1'b0);
      cyc("t1_bb", 8'hBB, 1'b1, 1'b1, 1'b0, 1'b1);
      chk("t1_run", 64'h1AA01, 7'd17, 1'b0);
      cyc("t1_flush", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("t1_lit", 64'h0BB, 7'd9, 1'b1);
      cyc("t1_idle", 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("t1_idle", 64'h0, 7'd0, 1'b0);

      // 12 34(last): two literals.
      cyc("t2_12", 8'h12, 1'b1, 1'b0, 1'b0, 1'b1);
      chk("t2_12", 64'h0, 7'd0, 1'b0);
      cyc("t2_34", 8'h34, 1'b1, 1'b1, 1'b0, 1'b1);
      chk("t2_lit12", 64'h012, 7'd9, 1'b0);
      cyc("t2_flush", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("t2_lit34", 64'h034, 7'd9, 1'b1);
      cyc("t2_idle", 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("t2_idle", 64'h0, 7'd0, 1'b0);

      // 258 zeros: run forced out at 257, final byte as literal.
      for (int i = 0; i < 257; i++) begin
         cyc("t3_zero", 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
         if (bus.valid_bits !== 7'd0) nz++;
      end
      total++;
      assert (nz === 0) else begin
         bad++;
         $error("FAIL t3_quiet early tokens got %0d want 0", nz);
      end
      cyc("t3_last", 8'h00, 1'b1, 1'b1, 1'b0, 1'b1);
      chk("t3_max", 64'h100FF, 7'd17, 1'b0);
      cyc("t3_flush", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("t3_lit", 64'h000, 7'd9, 1'b1);
      cyc("t3_idle", 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("t3_idle", 64'h0, 7'd0, 1'b0);

      // 11 11 22 22(last) with a 3-cycle stall while the first token is out.
      cyc("t4_11a", 8'h11, 1'b1, 1'b0, 1'b0, 1'b1);
      cyc("t4_11b", 8'h11, 1'b1, 1'b0, 1'b0, 1'b1);
      cyc("t4_22a", 8'h22, 1'b1, 1'b0, 1'b0, 1'b1);
      chk("t4_tok", 64'h11100, 7'd17, 1'b0);
      for (int i = 0; i < 3; i++) begin
         cyc("t4_stall", 8'h22, 1'b1, 1'b1, 1'b1, 1'b0);
         chk("t4_hold", 64'h11100, 7'd17, 1'b0);
      end
      cyc("t4_22b", 8'h22, 1'b1, 1'b1, 1'b0, 1'b1);
      chk("t4_fin", 64'h12200, 7'd17, 1'b1);
      cyc("t4_idle", 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("t4_idle", 64'h0, 7'd0, 1'b0);

      // Reset mid-run (together with stall) discards the partial run.
      for (int i = 0; i < 5; i++) begin
         cyc("t5_55", 8'h55, 1'b1, 1'b0, 1'b0, 1'b1);
      end
      rst = 1'b1;
      cyc("t5_rst", 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("t5_rst", 64'h0, 7'd0, 1'b0);
      rst = 1'b0;
      cyc("t5_66", 8'h66, 1'b1, 1'b1, 1'b0, 1'b1);
      chk("t5_66", 64'h066, 7'd9, 1'b1);
      cyc("t5_idle", 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("t5_idle", 64'h0, 7'd0, 1'b0);

      // Single byte 7E(last): literal in N+1, back in IDLE.
      cyc("t6_7e", 8'h7E, 1'b1, 1'b1, 1'b0, 1'b1);
      chk("t6_lit", 64'h07E, 7'd9, 1'b1);
      cyc("t6_idle", 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("t6_idle", 64'h0, 7'd0, 1'b0);

      // in_last without in_valid is ignored; run then ends on a real last.
      cyc("t7_44a", 8'h44, 1'b1, 1'b0, 1'b0, 1'b1);
      cyc("t7_ghost", 8'h99, 1'b0, 1'b1, 1'b0, 1'b1);
      chk("t7_ghost", 64'h0, 7'd0, 1'b0);
      cyc("t7_44b", 8'h44, 1'b1, 1'b1, 1'b0, 1'b1);
      chk("t7_run", 64'h14400, 7'd17, 1'b1);
      cyc("t7_idle", 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("t7_idle", 64'h0, 7'd0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rle_tokenizer.md
# rle_tokenizer

- Run-length front end of the compression path, directly upstream of the 64-bit bit-packer.
- Consumes a byte stream with valid/ready handshake and collapses repeated bytes into runs.
- Emits one variable-length token per cycle as a right-aligned code word plus bit count, with message-final flag, on the packer's `data_in`/`valid_bits`/`msg_fin` convention.
- Honours the packer-side `stall`.

## Interface
- `RUN_W`, 8: run-count field width.
  - Longest run is `MAX_RUN = 2**RUN_W + 1`.
  - Legal range 2..8.
- `clk` input 1: single clock, all logic on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_data` input 8: input byte.
- `in_valid` input 1: `in_data` valid this cycle.
- `in_last` input 1: byte is the last of the message; qualified by `in_valid`.
- `in_ready` output 1: block accepts a byte this cycle. A byte transfers when `in_valid && in_ready`.
- `stall` input 1: downstream not sampling. While high, all outputs hold.
- `data_out` output 64: token code, right-aligned.
  - Bits above `valid_bits` are zero.
  - Token MSB is transmitted first.
- `valid_bits` output 7: token length in bits; 0 means no token this cycle.
- `msg_fin` output 1: token is the last of the message.

## Operation
- Token formats, with `L` the run length:
  - `L==1`: `{1'b0, byte}`, 9 bits.
  - `2<=L<=MAX_RUN`: `{1'b1, byte, (L-2)[RUN_W-1:0]}`, 9+RUN_W bits.
- State:
  - FSM `IDLE`, `RUN`, `FLUSH`.
  - Registers `cur_byte[7:0]` and `cnt` (RUN_W+1 bits, 1..MAX_RUN).
- `in_ready = !stall && state != FLUSH`.
- `IDLE`, on accepted byte:
  - Load `cur_byte`, set `cnt=1`.
  - If `in_last`: emit the L=1 token with `msg_fin=1` and stay `IDLE`. Otherwise go to `RUN`.
- `RUN`, accepted byte equal to `cur_byte` and `cnt<MAX_RUN`:
  - `cnt++`.
  - If `in_last`: emit the run token, incremented count, with `msg_fin=1`, then go to `IDLE`.
- `RUN`, accepted byte different, or `cnt==MAX_RUN`:
  - Emit the current run token with `msg_fin=0`.
  - Load the new byte, `cnt=1`.
  - If `in_last`, go to `FLUSH`; else stay in `RUN`.
- `FLUSH`, when not stalled: emit the pending run token with `msg_fin=1`, go to `IDLE`.
- Cycles with no emission: `valid_bits=0`, `data_out=0`, `msg_fin=0`.
- Stall:
  - While `stall=1`, no input is accepted and the FSM and output registers are frozen.
  - The held token counts as consumed on the first cycle `stall=0`.
- Byte comparison is exact 8-bit equality. The count never wraps; at `MAX_RUN` the run is forced out.

## Timing
- Reset values: `state=IDLE`, `cnt=0`, `cur_byte=0`, `data_out=0`, `valid_bits=0`, `msg_fin=0`. `in_ready=1` once `rst` is low and `stall=0`.
- Outputs are registered. A token caused by the byte accepted in cycle N appears in cycle N+1.
- A `FLUSH` token appears in N+2.
- Throughput: at most one token and one byte per cycle.
- A break coinciding with `in_last` costs one bubble on `in_ready` (`FLUSH` cycle).
- `rst` mid-run discards the partial run with no token and no `msg_fin`. `rst` overrides `stall`.
- `in_last` without `in_valid` is ignored.
- Empty message (no bytes) produces nothing.

## Structure
- Package `rle_pkg` holds:
  - State enum.
  - `TOK_SHORT_W=9` and `tok_long_w(RUN_W)` function.
  - Flag encodings `LIT_FLAG=1'b0`, `RUN_FLAG=1'b1`.
  - `VB_W=7`.
- Sub-module `rle_token_fmt`: combinational `(byte, cnt) -> (code[63:0], len[6:0])`. It is instantiated once and the FSM registers its result.

## Test plan
- Reset, then AA AA AA BB(last) with `RUN_W=8`:
  - N+1: `data_out=0x1AA01`, `valid_bits=17`, `msg_fin=0`.
  - N+2: `data_out=0x0BB`, `valid_bits=9`, `msg_fin=1`.
  - `in_ready` low for exactly one cycle.
- 12 34(last): `0x012`/9/`fin=0`, then `0x034`/9/`fin=1`.
- 258 bytes of 0x00, last flagged:
  - Token `0x100FF`/17 (run 257 at `MAX_RUN`).
  - Then `0x000`/9 with `msg_fin=1`.
- `stall` held 3 cycles while a token is on the output:
  - Outputs stable.
  - `in_ready=0`.
  - No byte lost.
  - Token sequence identical to the unstalled run.
- `rst` asserted after 5×0x55: all outputs zero next cycle. Subsequent 0x66(last) yields only `0x066`/9/`fin=1`.
- Single byte 0x7E with `in_last`: `0x07E`/9/`fin=1` in N+1, `state` back to `IDLE`.
